add_sequencer: RTL

ADD_SEQUENCER -- requirements
Module: add_sequencer

---
 rtl/add_sequencer_pkg.sv | 10 +
 rtl/add_sequencer_nibble_add.sv | 13 +
 rtl/add_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/add_sequencer_pkg.sv
// Shared constants for the nibble-serial adder: slice width and FSM encoding.
package add_sequencer_pkg;

    localparam int unsigned SLICE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/add_sequencer_nibble_add.sv
// Combinational 4-bit slice adder; bit 4 of sum is the slice carry.
module nibble_add
    import add_sequencer_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W:0]   sum
);

    assign sum = (SLICE_W+1)'(a) + (SLICE_W+1)'(b) + (SLICE_W+1)'(cin);

endmodule

// File: rtl/add_sequencer.sv
// Nibble-serial unsigned adder: accepts a/b, adds one 4-bit slice per cycle,
// holds {cout,result} until the consumer takes it.
module add_sequencer
    import add_sequencer_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SLICE_W*NIBBLES-1:0]   a,
    input  logic [SLICE_W*NIBBLES-1:0]   b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SLICE_W*NIBBLES-1:0]   result,
    output logic                         cout,
    output logic                         busy
);

    localparam int unsigned IDX_W = $clog2(NIBBLES);

    logic [1:0]                        state_q, state_nx;
    logic [IDX_W-1:0]                  idx_q, idx_nx;
    logic                              carry_q, carry_nx;
    logic                              cout_nx;
    logic [NIBBLES-1:0][SLICE_W-1:0]   a_q, a_nx;
    logic [NIBBLES-1:0][SLICE_W-1:0]   b_q, b_nx;
    logic [NIBBLES-1:0][SLICE_W-1:0]   res_q, res_nx;
    logic [SLICE_W:0]                  slice_sum;

    nibble_add u_nibble_add (
        .a   (a_q[idx_q]),
        .b   (b_q[idx_q]),
        .cin (carry_q),
        .sum (slice_sum)
    );

    // Next-state and datapath update
    always_comb begin
        state_nx = state_q;
        idx_nx   = idx_q;
        carry_nx = carry_q;
        cout_nx  = cout;
        a_nx     = a_q;
        b_nx     = b_q;
        res_nx   = res_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_nx     = a;
                    b_nx     = b;
                    idx_nx   = '0;
                    carry_nx = 1'b0;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                res_nx[idx_q] = slice_sum[SLICE_W-1:0];
                carry_nx      = slice_sum[SLICE_W];
                if (idx_q == IDX_W'(NIBBLES-1)) begin
                    cout_nx  = slice_sum[SLICE_W];
                    idx_nx   = '0;
                    state_nx = ST_HOLD;
                end else begin
                    idx_nx = idx_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            cout      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_nx;
            idx_q     <= idx_nx;
            carry_q   <= carry_nx;
            cout      <= cout_nx;
            a_q       <= a_nx;
            b_q       <= b_nx;
            res_q     <= res_nx;
            in_ready  <= (state_nx == ST_IDLE);
            out_valid <= (state_nx == ST_HOLD);
            busy      <= (state_nx != ST_IDLE);
        end
    end

    assign result = res_q;

endmodule
